clk_step_ctrl: RTL and testbench
================================

Name: clk_step_ctrl

Overview:
- Sits directly downstream of the clock divider. Samples the divided clock (`clkDiv`) in the fast clock domain and turns each rising edge into a one-cycle CPU enable pulse (`cpuEn`).
- Adds free-run / single-step control for board debugging of the MIPS core. Inputs are a debounced step button and a synchronized run switch.
- The core and its pipeline registers stay on `clk` and advance only when `cpuEn`=1.

Parameters:
- DB_WIDTH, 16, width of the debounce counter.
- DB_COUNT, 50000, consecutive stable `clk` cycles required to accept a new button level; must satisfy 2 ≤ DB_COUNT ≤ 2^DB_WIDTH.
- CNT_WIDTH, 16, width of the executed-cycle counter.

Ports:
- clk  input  1  fast system clock; also drives the clock divider.
- reset  input  1  synchronous, active-high reset.
- clkDiv  input  1  divided clock from the divider; same clock domain, updated on negedge clk.
- btnStep  input  1  raw step push-button, asynchronous and bouncy.
- swRun  input  1  raw run switch, asynchronous; 1 = free run, 0 = stepping.
- cpuEn  output  1  one-cycle CPU advance enable.
- mode  output  2  current state: 00 RUN, 01 PAUSE, 10 STEP.
- stepCount  output  CNT_WIDTH  number of `cpuEn` pulses issued since reset.

Behaviour:
- Reset is synchronous and active-high on the posedge of `clk`. All registers clear: synchronizers 0, debounce counter 0, stable button 0, state PAUSE (`mode`=01), `cpuEn`=0, `stepCount`=0.
- Reset asserted mid-operation aborts any pending STEP. No `cpuEn` is issued in the reset cycle.
- clkDiv edge detect:
  - `clkDiv` is registered into `d1`, then `d2`.
  - `divRise` = `d1` & ~`d2`.
  - Exactly one `divRise` per divider period.
- swRun: 2-flop synchronizer giving `runS`. No debounce.
- btnStep path:
  - 2-flop synchronizer gives `btnS`.
  - Debouncer: if `btnS`==`stable`, counter←0. Otherwise counter←counter+1, and when counter==DB_COUNT-1 it sets `stable`←`btnS` and counter←0.
  - Any glitch back to the stable level restarts the count.
  - `stepReq` = one-cycle pulse on the 0→1 transition of `stable`, registered.
  - A clean press produces `stepReq` DB_COUNT+3 cycles after `btnStep` rises. Release generates nothing.
- State machine (registered; `cpuEn` is a registered output):
  - PAUSE: `cpuEn`=0.
    - `runS`=1 → RUN.
    - Else `stepReq` → STEP.
    - Else stay in PAUSE.
  - RUN: `cpuEn`←`divRise`.
    - `runS`=0 → PAUSE next cycle.
    - A `divRise` in that same cycle still produces its pulse.
  - STEP: wait for `divRise`; then `cpuEn`←1 for one cycle and → PAUSE.
    - `runS` is ignored until the step completes.
  - `stepReq` arriving in RUN or STEP is dropped, not queued.
  - Simultaneous `runS`=1 and `stepReq` in PAUSE: RUN wins, step is dropped.
- `cpuEn` is never high on two consecutive cycles and never more than once per `clkDiv` period.
- `stepCount` increments by 1 in the cycle `cpuEn` is asserted and wraps from 2^CNT_WIDTH-1 to 0.
- `mode` reflects the registered state directly.

Optional Feature:
- Macro CLK_STEP_CNT_EN.
- Defined: `stepCount` counter is implemented as described above.
- Undefined: counter is not built and `stepCount` is tied to 0. All other behaviour is identical.

Test Plan (DB_COUNT=4, `clkDiv` toggling every 6 `clk` cycles, period 12):
- Reset held 3 cycles, then released with `swRun`=0 → `mode`=01, `cpuEn`=0 and `stepCount`=0 for the next 100 cycles.
- Set `swRun`=1 → `mode`=00 within 3 cycles; `cpuEn` pulses every 12 cycles; `stepCount`=10 after the 10th pulse.
- `swRun`=0 with clean 20-cycle `btnStep` press → `stepReq` 7 cycles after rise, `mode`=10, exactly one `cpuEn` at next `divRise`, back to `mode`=01, `stepCount`+1.
- `btnStep` bouncing 1,0,1,0 each for 2 cycles, then held 1 → exactly one step; no extra `cpuEn`.
- Second clean press while in STEP → ignored; total pulses = 1.
- Assert reset during STEP before `divRise` → no `cpuEn`, `mode`=01, `stepCount`=0. With CLK_STEP_CNT_EN undefined, `stepCount` stays 0 in all scenarios.

Source files
------------

// File: rtl/clk_step_ctrl.sv
// CPU clock-enable generator with free-run / single-step debug control.
// Optional executed-cycle counter on stepCount, built when CLK_STEP_CNT_EN is defined.
module clk_step_ctrl #(
    parameter int unsigned DB_WIDTH  = 16,
    parameter int unsigned DB_COUNT  = 50000,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clkDiv,
    input  logic                 btnStep,
    input  logic                 swRun,
    output logic                 cpuEn,
    output logic [1:0]           mode,
    output logic [CNT_WIDTH-1:0] stepCount
);

    localparam logic [DB_WIDTH-1:0] DB_LAST = DB_WIDTH'(DB_COUNT - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_PAUSE = 2'b01,
        ST_STEP  = 2'b10
    } state_t;

    logic                r_div_d1;
    logic                r_div_d2;
    logic                r_run_s1;
    logic                r_run_s;
    logic                r_btn_s1;
    logic                r_btn_s;
    logic [DB_WIDTH-1:0] r_db_cnt;
    logic                r_stable;
    logic                r_stable_d;
    logic                r_step_req;
    state_t              r_state;
    logic                r_cpu_en;

    logic                w_div_rise;
    logic                w_fire;

    assign w_div_rise = r_div_d1 & ~r_div_d2;
    // Every divider rising edge seen while running or stepping advances the core.
    assign w_fire     = w_div_rise & ((r_state == ST_RUN) | (r_state == ST_STEP));

    // Input synchronizers, edge detect and button debouncer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_d1   <= 1'b0;
            r_div_d2   <= 1'b0;
            r_run_s1   <= 1'b0;
            r_run_s    <= 1'b0;
            r_btn_s1   <= 1'b0;
            r_btn_s    <= 1'b0;
            r_db_cnt   <= '0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_step_req <= 1'b0;
        end else begin
            r_div_d1   <= clkDiv;
            r_div_d2   <= r_div_d1;
            r_run_s1   <= swRun;
            r_run_s    <= r_run_s1;
            r_btn_s1   <= btnStep;
            r_btn_s    <= r_btn_s1;
            r_stable_d <= r_stable;
            r_step_req <= r_stable & ~r_stable_d;
            // A return to the accepted level restarts the stability count.
            if (r_btn_s == r_stable) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_stable <= r_btn_s;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_WIDTH'(1);
            end
        end
    end

    // Run / pause / step controller; step requests outside PAUSE are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_PAUSE;
            r_cpu_en <= 1'b0;
        end else begin
            r_cpu_en <= w_fire;
            case (r_state)
                ST_PAUSE: begin
                    if (r_run_s) begin
                        r_state <= ST_RUN;
                    end else if (r_step_req) begin
                        r_state <= ST_STEP;
                    end
                end
                ST_RUN: begin
                    if (!r_run_s) begin
                        r_state <= ST_PAUSE;
                    end
                end
                ST_STEP: begin
                    if (w_div_rise) begin
                        r_state <= ST_PAUSE;
                    end
                end
                default: r_state <= ST_PAUSE;
            endcase
        end
    end

`ifdef CLK_STEP_CNT_EN
    logic [CNT_WIDTH-1:0] r_step_cnt;

    // Counts issued enables; updates on the same edge that raises cpuEn.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_step_cnt <= '0;
        end else if (w_fire) begin
            r_step_cnt <= r_step_cnt + CNT_WIDTH'(1);
        end
    end

    assign stepCount = r_step_cnt;
`else
    assign stepCount = '0;
`endif

    assign cpuEn = r_cpu_en;
    assign mode  = r_state;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Bench for clk_step_ctrl: vector table, directed step/reset sequences and
// random run/button activity checked cycle by cycle against a history-based model.
module tb_clk_step_ctrl;

    localparam int unsigned DB      = 4;
    localparam int unsigned CW      = 16;
    localparam int          DIV_PER = 12;

`ifdef CLK_STEP_CNT_EN
    localparam logic [CW-1:0] CNT_MASK = '1;
`else
    localparam logic [CW-1:0] CNT_MASK = '0;
`endif

    logic          clk;
    logic          reset;
    logic          clkDiv;
    logic          btnStep;
    logic          swRun;
    logic          cpuEn;
    logic [1:0]    mode;
    logic [CW-1:0] stepCount;

    clk_step_ctrl #(
        .DB_WIDTH  (16),
        .DB_COUNT  (DB),
        .CNT_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clkDiv    (clkDiv),
        .btnStep   (btnStep),
        .swRun     (swRun),
        .cpuEn     (cpuEn),
        .mode      (mode),
        .stepCount (stepCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Divider model: toggles on the falling edge every 6 clk cycles.
    initial begin
        clkDiv = 1'b0;
        forever begin
            repeat (6) @(negedge clk);
            clkDiv = ~clkDiv;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks   = 0;
    int n_fail     = 0;
    int cyc        = 0;
    int n_pulse    = 0;
    int last_pulse = -1;

    // Reference model: bit 0 of each history is the sample from the previous edge.
    logic [7:0]    h_div;
    logic [7:0]    h_run;
    logic [7:0]    h_btn;
    logic [7:0]    h_st;
    logic [1:0]    m_state;
    logic          m_en;
    logic          m_stable;
    logic [CW-1:0] m_cnt;

    typedef struct {
        string       name;
        logic [31:0] wave;
        int          len;
        int          exp_pulses;
        logic [1:0]  exp_mode;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        logic rise;
        logic run_s;
        logic req;
        logic flip;
        logic en_n;
        if (reset) begin
            h_div    = '0;
            h_run    = '0;
            h_btn    = '0;
            h_st     = '0;
            m_state  = 2'b01;
            m_en     = 1'b0;
            m_stable = 1'b0;
            m_cnt    = '0;
            return;
        end
        rise  = h_div[0] & ~h_div[1];
        run_s = h_run[1];
        req   = h_st[1] & ~h_st[2];
        // New level accepted after DB consecutive synchronized samples differ from it.
        flip  = 1'b1;
        for (int k = 0; k < int'(DB); k++) begin
            if (h_btn[1+k] == m_stable) flip = 1'b0;
        end
        en_n = 1'b0;
        case (m_state)
            2'b01: begin
                if (run_s) m_state = 2'b00;
                else if (req) m_state = 2'b10;
            end
            2'b00: begin
                en_n = rise;
                if (!run_s) m_state = 2'b01;
            end
            2'b10: begin
                if (rise) begin
                    en_n    = 1'b1;
                    m_state = 2'b01;
                end
            end
            default: m_state = 2'b01;
        endcase
        m_en = en_n;
        if (en_n) m_cnt = m_cnt + CW'(1);
        if (flip) m_stable = ~m_stable;
        h_div = {h_div[6:0], clkDiv};
        h_run = {h_run[6:0], swRun};
        h_btn = {h_btn[6:0], btnStep};
        h_st  = {h_st[6:0], m_stable};
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        chk("cpuEn", 32'(cpuEn), 32'(m_en));
        chk("mode", 32'(mode), 32'(m_state));
        chk("stepCount", 32'(stepCount), 32'(m_cnt & CNT_MASK));
        if (reset) last_pulse = -1;
        if (cpuEn === 1'b1) begin
            n_pulse++;
            if (last_pulse >= 0) chk("pulse_spacing_ge_12", 32'((cyc - last_pulse) >= DIV_PER), 32'd1);
            last_pulse = cyc;
        end
    endtask

    task automatic wait_mode(input logic [1:0] tgt, input int budget, input string name);
        int n;
        n = 0;
        while (mode !== tgt && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(mode), 32'(tgt));
    endtask

    initial begin
        int            pt[10];
        int            got;
        int            p0;
        logic [CW-1:0] c0;
        int            seg;
        int            hold;
        int            c;

        reset   = 1'b1;
        swRun   = 1'b0;
        btnStep = 1'b0;

        vecs[0] = '{name: "clean_press_20", wave: 32'h000F_FFFF, len: 20, exp_pulses: 1, exp_mode: 2'b01};
        vecs[1] = '{name: "bounce_then_hold", wave: 32'h0FFF_FF33, len: 28, exp_pulses: 1, exp_mode: 2'b01};
        vecs[2] = '{name: "glitch_3", wave: 32'h0000_0007, len: 3, exp_pulses: 0, exp_mode: 2'b01};
        vecs[3] = '{name: "press_exactly_db", wave: 32'h0000_000F, len: 4, exp_pulses: 1, exp_mode: 2'b01};
        vecs[4] = '{name: "split_glitches", wave: 32'h0000_0077, len: 8, exp_pulses: 0, exp_mode: 2'b01};

        // Reset and idle pause.
        repeat (3) tick();
        chk("reset_mode", 32'(mode), 32'd1);
        chk("reset_cpuEn", 32'(cpuEn), 32'd0);
        chk("reset_stepCount", 32'(stepCount), 32'd0);
        reset = 1'b0;
        p0 = n_pulse;
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("idle_mode", 32'(mode), 32'd1);
        end
        chk("idle_pulses", 32'(n_pulse - p0), 32'd0);
        chk("idle_stepCount", 32'(stepCount), 32'd0);

        // Free run.
        swRun = 1'b1;
        repeat (3) tick();
        chk("run_entry_mode", 32'(mode), 32'd0);
        got = 0;
        for (int i = 0; i < 200 && got < 10; i++) begin
            tick();
            if (cpuEn === 1'b1) begin
                pt[got] = cyc;
                got++;
            end
        end
        chk("run_pulses", 32'(got), 32'd10);
        for (int i = 1; i < 10; i++) chk("run_period", 32'(pt[i] - pt[i-1]), 32'(DIV_PER));
        chk("run_count10", 32'(stepCount), 32'(CW'(10) & CNT_MASK));
        swRun = 1'b0;
        wait_mode(2'b01, 10, "run_exit_mode");
        repeat (30) tick();

        // Button waveform table.
        for (int v = 0; v < 5; v++) begin
            p0 = n_pulse;
            c0 = m_cnt;
            for (int i = 0; i < vecs[v].len; i++) begin
                btnStep = vecs[v].wave[i];
                tick();
            end
            btnStep = 1'b0;
            repeat (50) tick();
            chk({"tbl_", vecs[v].name, "_pulses"}, 32'(n_pulse - p0), 32'(vecs[v].exp_pulses));
            chk({"tbl_", vecs[v].name, "_mode"}, 32'(mode), 32'(vecs[v].exp_mode));
            chk({"tbl_", vecs[v].name, "_count"}, 32'(stepCount),
                32'((c0 + CW'(vecs[v].exp_pulses)) & CNT_MASK));
        end

        // Second press while in STEP: step entered just after a divider edge.
        @(posedge clkDiv);
        tick();
        repeat (5) tick();
        p0 = n_pulse;
        c0 = m_cnt;
        btnStep = 1'b1;
        repeat (5) tick();
        btnStep = 1'b0;
        repeat (2) tick();
        chk("step_latency_pre", 32'(mode), 32'd1);
        tick();
        chk("step_latency_entry", 32'(mode), 32'd2);
        repeat (2) tick();
        btnStep = 1'b1;
        repeat (5) tick();
        btnStep = 1'b0;
        repeat (60) tick();
        chk("step_in_step_pulses", 32'(n_pulse - p0), 32'd1);
        chk("step_in_step_mode", 32'(mode), 32'd1);
        chk("step_in_step_count", 32'(stepCount), 32'((c0 + CW'(1)) & CNT_MASK));

        // Reset while STEP waits for the divider edge.
        @(posedge clkDiv);
        tick();
        repeat (5) tick();
        btnStep = 1'b1;
        repeat (6) tick();
        btnStep = 1'b0;
        repeat (2) tick();
        chk("abort_step_mode", 32'(mode), 32'd2);
        reset = 1'b1;
        tick();
        chk("abort_reset_cpuEn", 32'(cpuEn), 32'd0);
        chk("abort_reset_mode", 32'(mode), 32'd1);
        chk("abort_reset_count", 32'(stepCount), 32'd0);
        tick();
        reset = 1'b0;
        p0 = n_pulse;
        repeat (40) tick();
        chk("abort_after_pulses", 32'(n_pulse - p0), 32'd0);
        chk("abort_after_mode", 32'(mode), 32'd1);
        chk("abort_after_count", 32'(stepCount), 32'd0);

        // Random run switch, bouncy button and occasional reset.
        for (int it = 0; it < 40; it++) begin
            swRun = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b1;
                repeat ($urandom_range(1, 2)) tick();
                reset = 1'b0;
            end
            seg = int'($urandom_range(30, 120));
            c   = 0;
            while (c < seg) begin
                btnStep = 1'($urandom_range(0, 1));
                hold    = int'($urandom_range(1, 8));
                repeat (hold) tick();
                c += hold;
            end
        end
        btnStep = 1'b0;
        swRun   = 1'b0;
        repeat (60) tick();
        chk("final_mode", 32'(mode), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
